mu_afespi: RTL
==============

MU_AFESPI -- requirements
Module: mu_afespi

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries; power of two, 2..16.
REQ-002 Parameter DIVW, default 8: width of the clock-divider field.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 s_apb_psel, s_apb_penable, s_apb_pwrite  input  1 each  APB3 slave controls.
REQ-006 s_apb_paddr  input  32  byte address; only [3:2] decoded.
REQ-007 s_apb_pwdata  input  32  write data.
REQ-008 s_apb_prdata  output  32  read data; the block also drives s_apb_pready as a 1-bit output.
REQ-009 afe_sck  output  1  AD9990 serial clock.
REQ-010 afe_sl  output  1  AD9990 serial load (active-low frame).
REQ-011 afe_sdata  output  1  AD9990 serial data.

Function
REQ-012 APB: s_apb_pready is constant 1 (zero wait states).
REQ-013 APB writes take effect on a clk edge with psel & penable & pwrite.
REQ-014 s_apb_prdata is combinational from the register state; unmapped bits read 0.
REQ-015 Register 0x0 DATA (write-only, reads 0): a write pushes {pwdata[31:8] data24, pwdata[7:0] addr8} into the FIFO.
REQ-016 DATA push when full: the word is dropped and sticky OVF is set. Fullness is evaluated before any same-cycle pop.
REQ-017 Register 0x4 STATUS, read: bit0 BUSY, bit1 EMPTY, bit2 FULL, bit3 OVF, bits[8:4] LEVEL (0..FIFO_DEPTH).
REQ-018 STATUS write: writing 1 to bit3 clears OVF; a same-cycle overflow wins and OVF stays 1.
REQ-019 Register 0x8 CLKDIV, RW, bits[DIVW-1:0]: half-period H = CLKDIV+1 clk cycles.
REQ-020 Register 0xC CTRL, RW: bit0 EN.
REQ-021 FSM states: IDLE, SETUP, SHIFT, HOLD.
REQ-022 IDLE: afe_sl=1, afe_sck=0, afe_sdata=0, BUSY=0.
REQ-023 IDLE exit: if EN=1 and the FIFO is not empty, pop one word, latch the word and H, and go to SETUP on the next edge.
REQ-024 Shift order: 32 bits, LSB first, addr[0..7] then data[0..23].
REQ-025 SETUP (duration H): afe_sl=0, afe_sck=0, afe_sdata=bit0.
REQ-026 SHIFT, per bit n=0..31: afe_sck=1 for H, then afe_sck=0 for H. afe_sdata changes to bit n+1 only at the falling edge; bit31 holds through its low half.
REQ-027 Data is stable throughout each sck-high phase, so the AFE samples on the rising edge.
REQ-028 HOLD (duration H): afe_sl=1, afe_sck=0, afe_sdata=0; then return to IDLE.
REQ-029 BUSY=1 in SETUP, SHIFT and HOLD.
REQ-030 Frame length: 66·H clk from entering SETUP to entering IDLE; back-to-back words are separated by exactly one IDLE cycle.
REQ-031 Half-period counter: a DIVW-bit down-counter loaded with the latched CLKDIV. A phase ends when the counter is 0; no wrap glitch at CLKDIV = 2^DIVW−1.
REQ-032 Bit counter: 5 bits; SHIFT exits after the low half of bit 31.
REQ-033 CLKDIV writes during a frame do not affect that frame.
REQ-034 EN cleared mid-frame: the current frame completes; no further pops occur.
REQ-035 Outputs are registered and glitch-free.

Reset
REQ-036 rst=1 forces on the next edge: FSM=IDLE, FIFO emptied (LEVEL=0), OVF=0, EN=0, CLKDIV=4, afe_sl=1, afe_sck=0, afe_sdata=0.
REQ-037 Reset mid-frame aborts the frame immediately with no further sck edges.
REQ-038 APB writes in a reset cycle are ignored.

Verification
REQ-039 Single frame: CLKDIV=0, EN=1, DATA=0x000001_A5 -> afe_sl low for 65 clk, 32 sck pulses of 1 clk each, sdata sequence 1,0,1,0,0,1,0,1,1,0×23, then IDLE after 66 clk total.
REQ-040 Divider: CLKDIV=3, one word -> each sck high/low phase lasts 4 clk; frame lasts 264 clk.
REQ-041 Overflow: EN=0, push 5 words with FIFO_DEPTH=4 -> LEVEL=4, FULL=1, OVF=1. Writing STATUS=0x8 -> OVF=0. EN=1 sends exactly 4 frames, each separated by 1 IDLE cycle.
REQ-042 Mid-frame changes: CLKDIV changed from 0 to 7 during frame 1 -> frame 1 keeps H=1 and frame 2 uses H=8. EN cleared during frame 1 -> frame 2 does not start.
REQ-043 Reset mid-frame: assert rst at bit 10 of a frame -> next edge gives afe_sl=1, afe_sck=0, LEVEL=0, CLKDIV readback=4, EN=0.
REQ-044 Push/pop race: FIFO full with a pop and a DATA write in the same cycle -> write dropped, OVF=1, LEVEL=FIFO_DEPTH−1.

Source files
------------

// File: rtl/mu_afespi.sv
// mu_afespi: APB3-programmed serial loader for the AD9990 analog front end.
// Queued 32-bit words are shifted out LSB-first, one frame per word.
module mu_afespi #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIVW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_apb_psel,
  input  logic        s_apb_penable,
  input  logic        s_apb_pwrite,
  input  logic [31:0] s_apb_paddr,
  input  logic [31:0] s_apb_pwdata,
  output logic [31:0] s_apb_prdata,
  output logic        s_apb_pready,
  output logic        afe_sck,
  output logic        afe_sl,
  output logic        afe_sdata
);
  // state  | meaning
  // IDLE   | link quiet; waits for EN and a queued word
  // SETUP  | frame open (sl low), bit0 presented ahead of the first sck rise
  // SHIFT  | 32 sck periods; r_hi selects the high or low half
  // HOLD   | sl released for one half-period before returning to IDLE
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  state_t          r_state, w_state_nxt;
  logic [DIVW-1:0] r_cnt, w_cnt_nxt;
  logic [DIVW-1:0] r_h, w_h_nxt;
  logic [4:0]      r_bit, w_bit_nxt;
  logic            r_hi, w_hi_nxt;
  logic [31:0]     r_shreg, w_shreg_nxt;
  logic            r_sl, r_sck, r_sdata;
  logic            w_sl_nxt, w_sck_nxt, w_sdata_nxt;

  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_ovf, r_en;
  logic [DIVW-1:0] r_clkdiv;

  logic            w_wr, w_push, w_pop, w_full, w_empty, w_busy, w_tc;
  logic [1:0]      w_sel;
  logic [4:0]      w_level5;
  logic            w_unused_paddr;

  assign w_sel          = s_apb_paddr[3:2];
  assign w_unused_paddr = ^{s_apb_paddr[31:4], s_apb_paddr[1:0]};
  assign w_wr           = s_apb_psel & s_apb_penable & s_apb_pwrite & ~rst;
  assign w_full         = (r_level == LW'(FIFO_DEPTH));
  assign w_empty        = (r_level == '0);
  // fullness is judged on the pre-pop level, so a push racing a pop is still dropped
  assign w_push         = w_wr && (w_sel == 2'd0) && !w_full;
  assign w_busy         = (r_state != S_IDLE);
  assign w_tc           = (r_cnt == '0);
  assign w_level5       = 5'(r_level);

  assign s_apb_pready = 1'b1;
  assign afe_sck      = r_sck;
  assign afe_sl       = r_sl;
  assign afe_sdata    = r_sdata;

  always_comb begin
    s_apb_prdata = '0;
    case (w_sel)
      2'd1:    s_apb_prdata = {23'd0, w_level5, r_ovf, w_full, w_empty, w_busy};
      2'd2:    s_apb_prdata[DIVW-1:0] = r_clkdiv;
      2'd3:    s_apb_prdata[0] = r_en;
      default: s_apb_prdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_clkdiv <= DIVW'(4);
    end else if (w_wr) begin
      if (w_sel == 2'd2) r_clkdiv <= s_apb_pwdata[DIVW-1:0];
      if (w_sel == 2'd3) r_en <= s_apb_pwdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_apb_pwdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      if (w_wr && (w_sel == 2'd0) && w_full)              r_ovf <= 1'b1;
      else if (w_wr && (w_sel == 2'd1) && s_apb_pwdata[3]) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_h     <= '0;
      r_bit   <= '0;
      r_hi    <= 1'b0;
      r_shreg <= '0;
      r_sl    <= 1'b1;
      r_sck   <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_h     <= w_h_nxt;
      r_bit   <= w_bit_nxt;
      r_hi    <= w_hi_nxt;
      r_shreg <= w_shreg_nxt;
      r_sl    <= w_sl_nxt;
      r_sck   <= w_sck_nxt;
      r_sdata <= w_sdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_h_nxt     = r_h;
    w_bit_nxt   = r_bit;
    w_hi_nxt    = r_hi;
    w_shreg_nxt = r_shreg;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en && !w_empty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = r_mem[r_rd_ptr];
          w_h_nxt     = r_clkdiv;
          w_cnt_nxt   = r_clkdiv;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tc) begin
          w_state_nxt = S_SHIFT;
          w_hi_nxt    = 1'b1;
          w_bit_nxt   = '0;
          w_cnt_nxt   = r_h;
        end else begin
          w_cnt_nxt = r_cnt - DIVW'(1);
        end
      end
      S_SHIFT: begin
        if (!w_tc) begin
          w_cnt_nxt = r_cnt - DIVW'(1);
        end else if (r_hi) begin
          // next bit appears with the falling sck edge; the last bit stays put
          w_hi_nxt  = 1'b0;
          w_cnt_nxt = r_h;
          if (r_bit != 5'd31) w_shreg_nxt = {1'b0, r_shreg[31:1]};
        end else if (r_bit == 5'd31) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = r_h;
        end else begin
          w_bit_nxt = r_bit + 5'd1;
          w_hi_nxt  = 1'b1;
          w_cnt_nxt = r_h;
        end
      end
      S_HOLD: begin
        if (w_tc) w_state_nxt = S_IDLE;
        else      w_cnt_nxt = r_cnt - DIVW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sl_nxt    = 1'b1;
    w_sck_nxt   = 1'b0;
    w_sdata_nxt = 1'b0;
    if (w_state_nxt == S_SETUP || w_state_nxt == S_SHIFT) begin
      w_sl_nxt    = 1'b0;
      w_sdata_nxt = w_shreg_nxt[0];
      w_sck_nxt   = (w_state_nxt == S_SHIFT) && w_hi_nxt;
    end
  end

endmodule
